cpu_controller: RTL and testbench
=================================

Name: cpu_controller

Overview:
- Single-cycle control unit for the team's 16-bit, 16-register CPU datapath.
- Holds the program counter (PC) and combinationally decodes the current instruction word (IR) into datapath controls:
  - register addresses DA/AA/BA
  - ALU function FS
  - mux selects MB/MD
  - write enables RW/MW
  - branch indicator BL
- D carries the register-file A-bus value, used for jumps and branch tests.

Parameters:
- PC_RESET, 16'h0000, PC value loaded on reset.

Ports:
- clk    in   1   system clock, rising-edge active
- reset  in   1   synchronous, active-high reset
- D      in   16  register-file A-bus data (value of register AA)
- IR     in   16  current instruction word, fetched externally from PC
- PC     out  16  program counter (registered)
- DA     out  4   destination register address
- AA     out  4   source A register address
- BA     out  4   source B register address / immediate field
- FS     out  3   ALU function select
- MB     out  1   B-operand mux: 0 = register B, 1 = zero-extended immediate IR[3:0]
- MD     out  1   writeback mux: 0 = ALU result, 1 = memory data
- RW     out  1   register-file write enable
- MW     out  1   data-memory write enable
- BL     out  1   branch/jump taken (PC loaded non-sequentially this cycle)

Behaviour:
- One clock (clk); reset is synchronous and active-high. On a rising edge with reset=1: PC <= PC_RESET.
- While reset=1, RW=MW=BL=0 regardless of IR. The other decode outputs still follow IR.
- Field decode (all opcodes): opcode=IR[15:12], DA=IR[11:8], AA=IR[7:4], BA=IR[3:0].
- FS encoding:
  - 000 ADD, 001 SUB (A-B), 010 AND, 011 OR
  - 100 XOR, 101 NOT A, 110 SHL A by 1, 111 pass B
- Defaults unless listed per opcode: FS=000, MB=0, MD=0, RW=0, MW=0, BL=0.
- Opcode table:
  - 0 NOP: no writes.
  - 1 ADD: FS=000, RW=1.
  - 2 SUB: FS=001, RW=1.
  - 3 AND: FS=010, RW=1.
  - 4 OR: FS=011, RW=1.
  - 5 XOR: FS=100, RW=1.
  - 6 NOT: FS=101, RW=1.
  - 7 SHL: FS=110, RW=1.
  - 8 LDI: FS=111, MB=1, RW=1 (DA <= zero-extended IR[3:0]).
  - 9 ADDI: FS=000, MB=1, RW=1.
  - A LD: MD=1, RW=1 (DA <= M[R[AA]]).
  - B ST: MW=1 (M[R[AA]] <= R[BA]).
  - C JMP: BL=1; next PC = D.
  - D BRZ: if D==16'h0000 then BL=1 and next PC = PC + sign-extended 8-bit offset {IR[11:8],IR[3:0]}; otherwise BL=0 and PC+1. RW=0.
  - E, F reserved: behave as NOP.
- All decode outputs are purely combinational from IR (and D, PC for BRZ). Zero latency within the cycle.
- PC update on each rising edge with reset=0: PC <= BL ? target : PC+1.
- Arithmetic is modulo 2^16:
  - PC+1 wraps FFFF -> 0000.
  - Branch target wraps in both directions.
- BRZ with offset 0 loads PC unchanged (self-loop) with BL=1.

Test Plan:
- Reset then IR=16'h8006 -> DA=0, AA=0, BA=6, FS=111, MB=1, MD=0, RW=1, MW=0, BL=0. PC 0000 -> 0001 at first edge after reset release.
- Reset held 3 cycles with IR=16'h1123 -> PC stays 0000; RW=0. After release: DA=1, AA=2, BA=3, FS=000, RW=1.
- IR=16'hB045 -> MW=1, RW=0, AA=4, BA=5. IR=16'hA340 -> MD=1, RW=1, DA=3.
- IR=16'hC010, D=16'h1234 -> BL=1; PC=1234 after the edge.
- PC=0010, IR=16'hDF2E, D=0 -> BL=1; offset FE (-2); PC=000E. Same IR with D=0001 -> BL=0; PC=0011.
- PC=FFFF, IR=16'h0000 -> PC wraps to 0000. IR=16'hF123 -> RW=MW=BL=0.

Source files
------------

// File: rtl/cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : cpu_controller
// Purpose  : Single-cycle control unit for a 16-bit, 16-register CPU.
//            Holds the program counter and combinationally decodes the
//            current instruction word into datapath controls.
// Ports    : clk    - system clock, rising-edge active
//            reset  - synchronous, active-high reset
//            D      - register-file A-bus data (value of register AA)
//            IR     - current instruction word (fetched from PC)
//            PC     - program counter (registered)
//            DA/AA/BA - destination / source A / source B (immediate) fields
//            FS     - ALU function select
//            MB, MD - B-operand mux and writeback mux selects
//            RW, MW - register-file and data-memory write enables
//            BL     - PC loaded non-sequentially this cycle
// Revision : 1.0 - initial release
// ============================================================================
module cpu_controller #(
    parameter logic [15:0] PC_RESET = 16'h0000
) (
    input  logic        clk,
    input  logic        reset,
    input  logic [15:0] D,
    input  logic [15:0] IR,
    output logic [15:0] PC,
    output logic [3:0]  DA,
    output logic [3:0]  AA,
    output logic [3:0]  BA,
    output logic [2:0]  FS,
    output logic        MB,
    output logic        MD,
    output logic        RW,
    output logic        MW,
    output logic        BL
);

    localparam logic [3:0] OP_NOP  = 4'h0;
    localparam logic [3:0] OP_ADD  = 4'h1;
    localparam logic [3:0] OP_SUB  = 4'h2;
    localparam logic [3:0] OP_AND  = 4'h3;
    localparam logic [3:0] OP_OR   = 4'h4;
    localparam logic [3:0] OP_XOR  = 4'h5;
    localparam logic [3:0] OP_NOT  = 4'h6;
    localparam logic [3:0] OP_SHL  = 4'h7;
    localparam logic [3:0] OP_LDI  = 4'h8;
    localparam logic [3:0] OP_ADDI = 4'h9;
    localparam logic [3:0] OP_LD   = 4'hA;
    localparam logic [3:0] OP_ST   = 4'hB;
    localparam logic [3:0] OP_JMP  = 4'hC;
    localparam logic [3:0] OP_BRZ  = 4'hD;

    logic [15:0] pc_q;
    logic [15:0] pc_d;

    logic [3:0]  w_opcode;
    logic [15:0] w_br_offset;
    logic [15:0] w_target;
    logic        w_rw;
    logic        w_mw;
    logic        w_bl;

    assign w_opcode = IR[15:12];
    // Branch offset straddles the DA and BA fields; sign-extend to 16 bits.
    assign w_br_offset = {{8{IR[11]}}, IR[11:8], IR[3:0]};

    always_comb begin
        FS       = 3'b000;
        MB       = 1'b0;
        MD       = 1'b0;
        w_rw     = 1'b0;
        w_mw     = 1'b0;
        w_bl     = 1'b0;
        w_target = pc_q + w_br_offset;

        case (w_opcode)
            OP_ADD:  begin FS = 3'b000; w_rw = 1'b1; end
            OP_SUB:  begin FS = 3'b001; w_rw = 1'b1; end
            OP_AND:  begin FS = 3'b010; w_rw = 1'b1; end
            OP_OR:   begin FS = 3'b011; w_rw = 1'b1; end
            OP_XOR:  begin FS = 3'b100; w_rw = 1'b1; end
            OP_NOT:  begin FS = 3'b101; w_rw = 1'b1; end
            OP_SHL:  begin FS = 3'b110; w_rw = 1'b1; end
            OP_LDI:  begin FS = 3'b111; MB = 1'b1; w_rw = 1'b1; end
            OP_ADDI: begin FS = 3'b000; MB = 1'b1; w_rw = 1'b1; end
            OP_LD:   begin MD = 1'b1; w_rw = 1'b1; end
            OP_ST:   begin w_mw = 1'b1; end
            OP_JMP:  begin w_bl = 1'b1; w_target = D; end
            OP_BRZ:  begin w_bl = (D == 16'h0000); end
            default: begin end // NOP and reserved opcodes E/F
        endcase
    end

    // Side-effecting strobes are suppressed while reset is held; the field
    // and mux decode keeps following IR.
    always_comb begin
        RW   = w_rw & ~reset;
        MW   = w_mw & ~reset;
        BL   = w_bl & ~reset;
        pc_d = BL ? w_target : (pc_q + 16'h0001);
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            pc_q <= PC_RESET;
        end else begin
            pc_q <= pc_d;
        end
    end

    assign PC = pc_q;
    assign DA = IR[11:8];
    assign AA = IR[7:4];
    assign BA = IR[3:0];

endmodule
`default_nettype wire

// File: tb/tb_cpu_controller.sv
`default_nettype none
// ============================================================================
// Module   : tb_cpu_controller
// Purpose  : Self-checking bench for cpu_controller. A table of directed
//            vectors (inputs, expected decode, expected PC after the edge)
//            is applied one per clock, followed by a short hand-written
//            reset/increment sequence.
// Revision : 1.0 - initial release
// ============================================================================
module tb_cpu_controller;

    logic        clk;
    logic        reset;
    logic [15:0] D;
    logic [15:0] IR;
    logic [15:0] PC;
    logic [3:0]  DA, AA, BA;
    logic [2:0]  FS;
    logic        MB, MD, RW, MW, BL;

    int checks;
    int errors;

    cpu_controller #(.PC_RESET(16'h0000)) dut (
        .clk   (clk),
        .reset (reset),
        .D     (D),
        .IR    (IR),
        .PC    (PC),
        .DA    (DA),
        .AA    (AA),
        .BA    (BA),
        .FS    (FS),
        .MB    (MB),
        .MD    (MD),
        .RW    (RW),
        .MW    (MW),
        .BL    (BL)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        logic        rst;
        logic [15:0] ir;
        logic [15:0] d;
        logic [3:0]  da, aa, ba;
        logic [2:0]  fs;
        logic        mb, md, rw, mw, bl;
        logic [15:0] pc;   // PC expected after the rising edge
    } vec_t;

    vec_t vecs[$];

    task automatic add(input logic rst, input logic [15:0] ir, input logic [15:0] d,
                       input logic [3:0] da, input logic [3:0] aa, input logic [3:0] ba,
                       input logic [2:0] fs, input logic mb, input logic md,
                       input logic rw, input logic mw, input logic bl,
                       input logic [15:0] pc);
        vec_t v;
        v.rst = rst; v.ir = ir; v.d = d;
        v.da = da; v.aa = aa; v.ba = ba; v.fs = fs;
        v.mb = mb; v.md = md; v.rw = rw; v.mw = mw; v.bl = bl;
        v.pc = pc;
        vecs.push_back(v);
    endtask

    task automatic check16(input string name, input logic [15:0] act, input logic [15:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    task automatic check_dec(input int idx, input logic [19:0] act, input logic [19:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL decode[%0d] {DA,AA,BA,FS,MB,MD,RW,MW,BL}: got %h expected %h",
                     idx, act, exp);
        end
    endtask

    initial begin
        checks = 0;
        errors = 0;
        reset  = 1'b1;
        IR     = 16'h0000;
        D      = 16'h0000;

        //   rst  IR        D         DA    AA    BA    FS     MB MD RW MW BL  PC after
        // Reset held three cycles: strobes gated, fields follow IR
        add(1, 16'h1123, 16'h0000, 4'h1, 4'h2, 4'h3, 3'b000, 0, 0, 0, 0, 0, 16'h0000);
        add(1, 16'h1123, 16'h0000, 4'h1, 4'h2, 4'h3, 3'b000, 0, 0, 0, 0, 0, 16'h0000);
        add(1, 16'h1123, 16'h0000, 4'h1, 4'h2, 4'h3, 3'b000, 0, 0, 0, 0, 0, 16'h0000);
        add(0, 16'h1123, 16'h0000, 4'h1, 4'h2, 4'h3, 3'b000, 0, 0, 1, 0, 0, 16'h0001);
        add(0, 16'h8006, 16'h0000, 4'h0, 4'h0, 4'h6, 3'b111, 1, 0, 1, 0, 0, 16'h0002);
        add(0, 16'hB045, 16'h0000, 4'h0, 4'h4, 4'h5, 3'b000, 0, 0, 0, 1, 0, 16'h0003);
        add(0, 16'hA340, 16'h0000, 4'h3, 4'h4, 4'h0, 3'b000, 0, 1, 1, 0, 0, 16'h0004);
        add(0, 16'hC010, 16'h1234, 4'h0, 4'h1, 4'h0, 3'b000, 0, 0, 0, 0, 1, 16'h1234);
        add(0, 16'h2567, 16'h0000, 4'h5, 4'h6, 4'h7, 3'b001, 0, 0, 1, 0, 0, 16'h1235);
        add(0, 16'h3000, 16'h0000, 4'h0, 4'h0, 4'h0, 3'b010, 0, 0, 1, 0, 0, 16'h1236);
        add(0, 16'h4000, 16'h0000, 4'h0, 4'h0, 4'h0, 3'b011, 0, 0, 1, 0, 0, 16'h1237);
        add(0, 16'h5000, 16'h0000, 4'h0, 4'h0, 4'h0, 3'b100, 0, 0, 1, 0, 0, 16'h1238);
        add(0, 16'h6000, 16'h0000, 4'h0, 4'h0, 4'h0, 3'b101, 0, 0, 1, 0, 0, 16'h1239);
        add(0, 16'h7000, 16'h0000, 4'h0, 4'h0, 4'h0, 3'b110, 0, 0, 1, 0, 0, 16'h123A);
        add(0, 16'h9123, 16'h0000, 4'h1, 4'h2, 4'h3, 3'b000, 1, 0, 1, 0, 0, 16'h123B);
        add(0, 16'hF123, 16'h0000, 4'h1, 4'h2, 4'h3, 3'b000, 0, 0, 0, 0, 0, 16'h123C);
        add(0, 16'hE000, 16'h0000, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 16'h123D);
        // BRZ taken backwards (-2) and not taken from PC=0010
        add(0, 16'hC000, 16'h0010, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 1, 16'h0010);
        add(0, 16'hDF2E, 16'h0000, 4'hF, 4'h2, 4'hE, 3'b000, 0, 0, 0, 0, 1, 16'h000E);
        add(0, 16'hC000, 16'h0010, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 1, 16'h0010);
        add(0, 16'hDF2E, 16'h0001, 4'hF, 4'h2, 4'hE, 3'b000, 0, 0, 0, 0, 0, 16'h0011);
        // BRZ offset 0 is a self-loop
        add(0, 16'hD000, 16'h0000, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 1, 16'h0011);
        // Forward branch wrapping past FFFF, then backward wrapping past 0000
        add(0, 16'hC000, 16'hFFF0, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 1, 16'hFFF0);
        add(0, 16'hD200, 16'h0000, 4'h2, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 1, 16'h0010);
        add(0, 16'hD800, 16'h0000, 4'h8, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 1, 16'hFF90);
        // Sequential wrap FFFF -> 0000
        add(0, 16'hC000, 16'hFFFF, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 1, 16'hFFFF);
        add(0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 16'h0000);
        add(0, 16'h0000, 16'h0000, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 16'h0001);
        // Reset gates JMP and ST strobes, then LDI after release
        add(1, 16'hC000, 16'h1234, 4'h0, 4'h0, 4'h0, 3'b000, 0, 0, 0, 0, 0, 16'h0000);
        add(1, 16'hB045, 16'h0000, 4'h0, 4'h4, 4'h5, 3'b000, 0, 0, 0, 0, 0, 16'h0000);
        add(0, 16'h8006, 16'h0000, 4'h0, 4'h0, 4'h6, 3'b111, 1, 0, 1, 0, 0, 16'h0001);

        for (int i = 0; i < vecs.size(); i++) begin
            @(negedge clk);
            reset = vecs[i].rst;
            IR    = vecs[i].ir;
            D     = vecs[i].d;
            #1;
            check_dec(i, {DA, AA, BA, FS, MB, MD, RW, MW, BL},
                      {vecs[i].da, vecs[i].aa, vecs[i].ba, vecs[i].fs,
                       vecs[i].mb, vecs[i].md, vecs[i].rw, vecs[i].mw, vecs[i].bl});
            @(posedge clk);
            #1;
            check16($sformatf("pc_after[%0d]", i), PC, vecs[i].pc);
        end

        // Hand sequence: reset from a nonzero PC, then three NOP increments.
        @(negedge clk);
        IR    = 16'hC000;
        D     = 16'hABCD;
        reset = 1'b0;
        @(posedge clk); #1;
        check16("seq_jmp_pc", PC, 16'hABCD);
        @(negedge clk);
        reset = 1'b1;
        IR    = 16'h0000;
        @(posedge clk); #1;
        check16("seq_reset_pc", PC, 16'h0000);
        @(negedge clk);
        reset = 1'b0;
        for (int k = 1; k <= 3; k++) begin
            #1;
            check16($sformatf("seq_nop_bl[%0d]", k), {15'd0, BL}, 16'h0000);
            @(posedge clk); #1;
            check16($sformatf("seq_nop_pc[%0d]", k), PC, 16'(k));
            @(negedge clk);
        end

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
`default_nettype wire
